// File: rtl/syn_filt.sv
// 10th-order LPC synthesis filter over a shared synchronous-read scratch memory.
// Each sample: y[n] = round(8*(x*a0 - sum a[j]*y[n-j])) with saturating 32-bit arithmetic.
module syn_filt #(
  parameter int          LG       = 40,
  parameter logic [10:0] A_ADDR   = 11'd0,
  parameter logic [10:0] X_ADDR   = 11'd16,
  parameter logic [10:0] Y_ADDR   = 11'd64,
  parameter logic [10:0] MEM_ADDR = 11'd112
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        update,
  input  logic [31:0] memIn,
  output logic [10:0] memRequested,
  output logic        memWrite,
  output logic [31:0] memOut,
  output logic        done
);

  localparam int NW = $clog2(LG);

  typedef enum logic [3:0] {
    IDLE, RD_X, RD_A0, MUL0, RD_A, RD_Y, MSU, SCALE, WR_Y, UPD_RD, UPD_WR, DONE
  } stateT;

  stateT              stateReg, stateNext;
  logic [NW-1:0]      nReg, nNext;
  logic [3:0]         jReg, jNext, kReg, kNext;
  logic signed [31:0] accReg, accNext;
  logic [15:0]        xReg, xNext, aReg, aNext, yReg, yNext;
  logic               updReg, updNext;
  logic [10:0]        nExt, jExt, yAddr;
  logic [3:0]         jInc;
  logic               unusedMemHi;

  assign unusedMemHi = ^memIn[31:16];

  function automatic logic signed [31:0] lMult(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    if (a == 16'sh8000 && b == 16'sh8000) return 32'sh7fffffff;
    return p <<< 1;
  endfunction

  function automatic logic signed [31:0] lSub(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [32:0] d;
    d = {a[31], a} - {b[31], b};
    if (d[32] != d[31]) return d[32] ? 32'sh80000000 : 32'sh7fffffff;
    return $signed(d[31:0]);
  endfunction

  function automatic logic signed [31:0] lShl3(input logic signed [31:0] s);
    if (s[31:28] == 4'b0000 || s[31:28] == 4'b1111) return $signed({s[28:0], 3'b000});
    return s[31] ? 32'sh80000000 : 32'sh7fffffff;
  endfunction

  // Only positive overflow is possible when adding the rounding constant.
  function automatic logic [15:0] roundHi(input logic signed [31:0] s);
    logic [32:0] sum;
    sum = {s[31], s} + 33'h0_0000_8000;
    if (sum[32] != sum[31]) return 16'h7fff;
    return sum[31:16];
  endfunction

  // Taps reaching before the frame start fall back into the history buffer.
  assign nExt  = {{(11-NW){1'b0}}, nReg};
  assign jExt  = {7'b0, jReg};
  assign jInc  = jReg + 4'd1;
  assign yAddr = (nExt >= jExt) ? (Y_ADDR + nExt - jExt) : (MEM_ADDR + 11'd10 + nExt - jExt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      nReg     <= '0;
      jReg     <= '0;
      kReg     <= '0;
      accReg   <= '0;
      xReg     <= '0;
      aReg     <= '0;
      yReg     <= '0;
      updReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      nReg     <= nNext;
      jReg     <= jNext;
      kReg     <= kNext;
      accReg   <= accNext;
      xReg     <= xNext;
      aReg     <= aNext;
      yReg     <= yNext;
      updReg   <= updNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    nNext        = nReg;
    jNext        = jReg;
    kNext        = kReg;
    accNext      = accReg;
    xNext        = xReg;
    aNext        = aReg;
    yNext        = yReg;
    updNext      = updReg;
    memRequested = '0;
    memWrite     = 1'b0;
    memOut       = '0;
    done         = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          updNext   = update;
          nNext     = '0;
          stateNext = RD_X;
        end
      end
      RD_X: begin
        memRequested = X_ADDR + nExt;
        stateNext    = RD_A0;
      end
      RD_A0: begin
        memRequested = A_ADDR;
        xNext        = memIn[15:0];
        stateNext    = MUL0;
      end
      MUL0: begin
        accNext   = lMult(xReg, memIn[15:0]);
        jNext     = 4'd1;
        stateNext = RD_A;
      end
      RD_A: begin
        memRequested = A_ADDR + jExt;
        stateNext    = RD_Y;
      end
      RD_Y: begin
        aNext        = memIn[15:0];
        memRequested = yAddr;
        stateNext    = MSU;
      end
      // Accumulate the current tap while already fetching the next coefficient.
      MSU: begin
        accNext = lSub(accReg, lMult(aReg, memIn[15:0]));
        if (jReg == 4'd10) begin
          stateNext = SCALE;
        end else begin
          jNext        = jInc;
          memRequested = A_ADDR + {7'b0, jInc};
          stateNext    = RD_Y;
        end
      end
      SCALE: begin
        yNext     = roundHi(lShl3(accReg));
        stateNext = WR_Y;
      end
      WR_Y: begin
        memWrite     = 1'b1;
        memRequested = Y_ADDR + nExt;
        memOut       = {{16{yReg[15]}}, yReg};
        if (nReg == NW'(LG - 1)) begin
          kNext     = '0;
          stateNext = updReg ? UPD_RD : DONE;
        end else begin
          nNext     = nReg + 1'b1;
          stateNext = RD_X;
        end
      end
      UPD_RD: begin
        memRequested = Y_ADDR + 11'(LG - 10) + {7'b0, kReg};
        stateNext    = UPD_WR;
      end
      UPD_WR: begin
        memWrite     = 1'b1;
        memRequested = MEM_ADDR + {7'b0, kReg};
        memOut       = {{16{memIn[15]}}, memIn[15:0]};
        if (kReg == 4'd9) begin
          stateNext = DONE;
        end else begin
          kNext     = kReg + 4'd1;
          stateNext = UPD_RD;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syn_filt.sv
// Scoreboard bench for syn_filt: expected memory writes are queued per frame
// and a negedge monitor compares every write strobe against the queue head.
module tb_syn_filt;

  localparam int          LG       = 40;
  localparam logic [10:0] A_ADDR   = 11'd0;
  localparam logic [10:0] X_ADDR   = 11'd16;
  localparam logic [10:0] Y_ADDR   = 11'd64;
  localparam logic [10:0] MEM_ADDR = 11'd112;
  localparam int          BOUND    = LG * 30 + 40;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
  } wrT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        update = 1'b0;
  logic [31:0] memIn;
  logic [10:0] memRequested;
  logic        memWrite;
  logic [31:0] memOut;
  logic        done;

  logic        tbWe = 1'b0;
  logic [10:0] tbAddr = '0;
  logic [31:0] tbData = '0;
  logic [31:0] mem [0:2047];

  wrT sbQ[$];
  int passCnt = 0;
  int totalCnt = 0;
  int writeCnt = 0;
  int cyc;

  always #5 clk = ~clk;

  syn_filt dut (
    .clk(clk), .reset(reset), .start(start), .update(update),
    .memIn(memIn), .memRequested(memRequested), .memWrite(memWrite),
    .memOut(memOut), .done(done)
  );

  // Synchronous-read scratch memory with a bench-side load port.
  always @(posedge clk) begin
    if (memWrite) mem[memRequested] <= memOut;
    else if (tbWe) mem[tbAddr] <= tbData;
    memIn <= mem[memRequested];
  end

  function automatic void check(string name, longint act, longint exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (memWrite) begin
      wrT e;
      writeCnt++;
      if (sbQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpectedWrite: got addr=%0d data=%0d expected no write",
                 memRequested, $signed(memOut));
      end else begin
        e = sbQ.pop_front();
        $display("write addr=%0d data=%0d (expect addr=%0d data=%0d)",
                 memRequested, $signed(memOut), e.addr, $signed(e.data));
        check("wrAddr", longint'(memRequested), longint'(e.addr));
        check("wrData", longint'($signed(memOut)), longint'($signed(e.data)));
      end
    end
  end

  task automatic loadWord(input int addr, input int data);
    tbWe = 1'b1;
    tbAddr = 11'(addr);
    tbData = 32'(data);
    @(posedge clk); #1;
    tbWe = 1'b0;
  endtask

  task automatic setup(input int a0, input int a1, input int x0, input int m9);
    for (int i = 0; i < 128; i++) loadWord(i, 0);
    loadWord(int'(A_ADDR), a0);
    loadWord(int'(A_ADDR) + 1, a1);
    loadWord(int'(X_ADDR), x0);
    loadWord(int'(MEM_ADDR) + 9, m9);
  endtask

  // 0: unity impulse, 1: decay with a1=-0.5, 2: same decay seeded from history.
  function automatic int expY(int kind, int n);
    case (kind)
      0:       return (n == 0) ? 4096 : 0;
      1:       return (n <= 12) ? (4096 >> n) : 1;
      default: return (n <= 11) ? (4096 >> (n + 1)) : 1;
    endcase
  endfunction

  task automatic pushWrite(input int addr, input int data);
    wrT e;
    e.addr = 11'(addr);
    e.data = 32'(data);
    sbQ.push_back(e);
  endtask

  task automatic pushFrame(input int kind);
    for (int n = 0; n < LG; n++) pushWrite(int'(Y_ADDR) + n, expY(kind, n));
  endtask

  task automatic runFrame(input logic upd, input int expWrites, output int cycles);
    writeCnt = 0;
    start = 1'b1;
    update = upd;
    cycles = 0;
    while (!done && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("runDone", longint'(done), 1);
    check("runLenBound", longint'(cycles <= BOUND), 1);
    repeat (3) @(posedge clk);
    #1;
    check("doneHeld", longint'(done), 1);
    check("writeCount", longint'(writeCnt), longint'(expWrites));
    check("queueDrained", longint'(sbQ.size()), 0);
    sbQ.delete();
    start = 1'b0;
    update = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("doneClear", longint'(done), 0);
  endtask

  initial begin
    #3;
    check("rstMemWrite", longint'(memWrite), 0);
    check("rstAddr", longint'(memRequested), 0);
    check("rstMemOut", longint'(memOut), 0);
    check("rstDone", longint'(done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    setup(4096, 0, 4096, 0);
    pushFrame(0);
    runFrame(1'b0, LG, cyc);

    setup(4096, -2048, 4096, 0);
    pushFrame(1);
    runFrame(1'b0, LG, cyc);

    setup(4096, -2048, 0, 4096);
    pushFrame(2);
    runFrame(1'b0, LG, cyc);
    check("histMem9Kept", longint'($signed(mem[MEM_ADDR + 11'd9])), 4096);
    check("histMem0Kept", longint'($signed(mem[MEM_ADDR])), 0);

    setup(32767, 0, 32767, 0);
    pushWrite(int'(Y_ADDR), 32767);
    for (int n = 1; n < LG; n++) pushWrite(int'(Y_ADDR) + n, 0);
    runFrame(1'b0, LG, cyc);

    setup(32767, 0, -32768, 0);
    pushWrite(int'(Y_ADDR), -32768);
    for (int n = 1; n < LG; n++) pushWrite(int'(Y_ADDR) + n, 0);
    runFrame(1'b0, LG, cyc);

    setup(4096, -2048, 4096, 0);
    pushFrame(1);
    for (int k = 0; k < 10; k++) pushWrite(int'(MEM_ADDR) + k, 1);
    runFrame(1'b1, LG + 10, cyc);
    for (int k = 0; k < 10; k++)
      check("updMem", longint'($signed(mem[MEM_ADDR + 11'(k)])), 1);

    // Abort a frame after five outputs, then confirm a clean restart.
    setup(4096, 0, 4096, 0);
    pushFrame(0);
    writeCnt = 0;
    start = 1'b1;
    cyc = 0;
    while (writeCnt < 5 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abortReached", longint'(writeCnt), 5);
    reset = 1'b0;
    #1;
    check("abortMemWrite", longint'(memWrite), 0);
    check("abortAddr", longint'(memRequested), 0);
    check("abortMemOut", longint'(memOut), 0);
    check("abortDone", longint'(done), 0);
    sbQ.delete();
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("abortNoWrites", longint'(writeCnt), 5);
    check("abortIdleDone", longint'(done), 0);
    pushFrame(0);
    runFrame(1'b0, LG, cyc);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/syn_filt.md
Name: syn_filt

Overview:
- 10th-order LPC synthesis filter. Computes y[n] = round(8·(x[n]·a[0] − Σ a[j]·y[n−j])) in G.729 fixed point, for j=1..10 and n=0..LG−1.
- Sits in the synthesis-filtering path beside convolve. Operands are read from the shared scratch memory and results are written back to it.
- Filter history memory is optionally updated at the end of a frame.
- Arithmetic (L_mult, L_msu, L_shl, round) is internal and saturating.

Parameters:
- LG, 40, samples per run.
- A_ADDR, 11'd0, base of a[0..10].
- X_ADDR, 11'd16, base of x[0..LG−1].
- Y_ADDR, 11'd64, base of y[0..LG−1].
- MEM_ADDR, 11'd112, base of history mem[0..9]. mem[9] = y[−1], mem[0] = y[−10].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begins a run when sampled high in IDLE.
- update  in  1  sampled with start; 1 = write y[LG−10..LG−1] into mem[0..9] after the run.
- memIn  in  32  read data; low 16 bits are the signed operand.
- memRequested  out  11  memory address.
- memWrite  out  1  write strobe.
- memOut  out  32  write data, 16-bit result sign-extended.
- done  out  1  run complete.

Behaviour:
- Reset values (while reset low, any state): state IDLE, done 0, memWrite 0, memRequested 0, memOut 0, accumulator 0, all counters 0. Reset mid-run aborts with no further writes.
- Memory timing: synchronous read. memIn corresponds to the memRequested presented the previous cycle. A write occurs on a clock edge where memWrite=1.
- States: IDLE, RD_X, RD_A0, MUL0, RD_A, RD_Y, MSU, SCALE, WR_Y, UPD_RD, UPD_WR, DONE.
- IDLE:
  - on start=1, latch update, set n=0, go to RD_X.
  - start=0 stays in IDLE.
- Per sample n:
  - Read x[n], then a[0].
  - s = L_mult(x,a0) = sat32(2·x·a0).
  - For j=1..10: read a[j], then read y[n−j]. The y address is Y_ADDR+n−j if n≥j, else MEM_ADDR+10+n−j.
  - s = sat32(s − sat32(2·a[j]·y)).
- SCALE:
  - s = sat32(s<<3), saturating to 0x7FFFFFFF / 0x80000000 on overflow of any shifted bit.
  - y = upper 16 bits of sat32(s + 0x8000).
- WR_Y:
  - Write y to Y_ADDR+n; memWrite high exactly one cycle.
  - If n<LG−1: n++, go to RD_X.
  - Else: go to UPD_RD if update, otherwise DONE.
- UPD_RD / UPD_WR:
  - For k=0..9: copy Y_ADDR+LG−10+k to MEM_ADDR+k.
  - Exactly 10 write strobes.
- DONE:
  - done=1 held.
  - Return to IDLE only when start=0, so a held start never retriggers.
  - done clears the cycle after leaving DONE.
- No writes to X, A or MEM regions except in UPD_WR.
- Run length is deterministic for a given update. The bench measures it and bounds it at ≤ LG·30 + 40 cycles.
- Samples are processed strictly in order. A y[n−j] read always observes the value written in an earlier WR_Y.

Test Plan:
- Impulse, unity:
  - Setup: a=[4096,0×10], x[0]=4096, others 0, mem=0, update=0.
  - Expect: y[0]=4096, y[1..39]=0.
  - Expect: done rises and holds while start high; 40 Y writes, no MEM writes.
- Recursive decay:
  - Setup: a=[4096,−2048,0×9], x impulse 4096, mem=0.
  - Expect: y[n]=4096>>n for n=0..12 (y[12]=1).
  - Expect: y[13..39]=1, since rounding keeps 1.
- History use:
  - Setup: x=0, a=[4096,−2048,0..], mem[9]=4096, mem[0..8]=0.
  - Expect: y[0]=2048, y[1]=1024.
  - Expect: mem contents unchanged with update=0.
- Saturation:
  - Setup: a0=32767, x[0]=32767, rest 0.
  - Expect: y[0]=32767 (L_shl and round both saturate).
  - Setup: a0=32767, x[0]=−32768.
  - Expect: y[0]=−32768.
- Update:
  - Setup: repeat the decay case with update=1.
  - Expect: mem[0..9]=1, exactly 50 write strobes total, then done.
- Reset mid-run:
  - Stimulus: assert reset low at sample 5.
  - Expect: outputs at reset values immediately and no further writes.
  - Expect: a subsequent start runs the full frame and reproduces the unity-impulse result.
